// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared definitions for the iterative multiply/divide unit:
//               operation encodings, FSM state type and default width.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_t;

  // Division ops have the high encoding bit set.
  function automatic logic is_div_op(input logic [1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // MULT and DIV treat operands as two's complement.
  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter
// Description : Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO. Radix-2
//               shift-add multiply and restoring divide, one bit per cycle,
//               followed by a sign-fix cycle that pulses done.
//               Optional macro MDU_FAST_MUL_EN: multiplies use a one-cycle
//               '*' product instead of the WIDTH-cycle iteration.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int               W2       = 2 * WIDTH;
  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Two's-complement negation at operand and product width.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [W2-1:0] neg_2w(input logic [W2-1:0] v);
    return ~v + W2'(1);
  endfunction

  mdu_state_t       state_q, state_d;
  logic             mul_q, mul_d;     // operation in flight is a multiply
  logic             neg_q, neg_d;     // product / quotient must be negated
  logic             rneg_q, rneg_d;   // remainder must be negated
  logic             divz_q, divz_d;   // divide by zero
  logic [WIDTH-1:0] a_q, a_d;         // raw dividend for the divide-by-zero result
  logic [WIDTH-1:0] ma_q, ma_d;       // |src_a|
  logic [WIDTH-1:0] mb_q, mb_d;       // |src_b|
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next;
  logic [WIDTH:0]   div_rsh;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [W2-1:0]    div_next;
  logic [W2-1:0]    step_next;
  logic             last;
  logic [W2-1:0]    fix_prod;
  logic [WIDTH-1:0] fix_quo;
  logic [WIDTH-1:0] fix_rem;
  logic             a_neg;
  logic             b_neg;

  // Datapath: one iteration step plus the sign-corrected final result.
  always_comb begin
    // Multiply: acc = {partial high, remaining multiplier bits}; add on LSB, shift right.
    mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, (acc_q[0] ? ma_q : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    // Divide: acc = {partial remainder, remaining dividend / quotient bits}.
    div_rsh  = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = (div_rsh >= {1'b0, mb_q});
    div_rem  = div_ge ? WIDTH'(div_rsh - {1'b0, mb_q}) : div_rsh[WIDTH-1:0];
    div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};

    step_next = mul_q ? mul_next : div_next;
    last      = (cnt_q == CNT_LAST);
`ifdef MDU_FAST_MUL_EN
    if (mul_q) begin
      step_next = {{WIDTH{1'b0}}, ma_q} * {{WIDTH{1'b0}}, mb_q};
      last      = 1'b1;
    end
`endif
    fix_prod = neg_q  ? neg_2w(step_next) : step_next;
    fix_quo  = neg_q  ? neg_w(step_next[WIDTH-1:0]) : step_next[WIDTH-1:0];
    fix_rem  = rneg_q ? neg_w(step_next[W2-1:WIDTH]) : step_next[W2-1:WIDTH];
  end

  // Control: next state, operand capture, iteration and result load.
  always_comb begin
    state_d = state_q;
    mul_d   = mul_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    divz_d  = divz_q;
    a_d     = a_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_neg   = is_signed_op(op) & src_a[WIDTH-1];
    b_neg   = is_signed_op(op) & src_b[WIDTH-1];

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mul_d   = !is_div_op(op);
          a_d     = src_a;
          ma_d    = a_neg ? neg_w(src_a) : src_a;
          mb_d    = b_neg ? neg_w(src_b) : src_b;
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          divz_d  = is_div_op(op) && (src_b == {WIDTH{1'b0}});
          cnt_d   = '0;
          acc_d   = {{WIDTH{1'b0}}, (is_div_op(op) ? ma_d : mb_d)};
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d = step_next;
        cnt_d = last ? '0 : cnt_q + CNT_W'(1);
        if (last) begin
          // Results are committed on entry to FIX so they are valid while done is high.
          state_d = ST_FIX;
          if (mul_q) begin
            hi_d = fix_prod[W2-1:WIDTH];
            lo_d = fix_prod[WIDTH-1:0];
          end else if (divz_q) begin
            hi_d = a_q;
            lo_d = {WIDTH{1'b1}};
          end else begin
            hi_d = fix_rem;
            lo_d = fix_quo;
          end
        end
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A flush wins over everything, including a start in the same cycle.
    if (cancel) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mul_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      divz_q  <= 1'b0;
      a_q     <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      mul_q   <= mul_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      divz_q  <= divz_d;
      a_q     <= a_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_FIX);
  assign stall = start | busy;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
`default_nettype wire

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit for the 5-stage pipeline. Sits beside the execute stage and consumes its operands. Computes MULT/MULTU/DIV/DIVU into HI/LO. Drives the execute stage's `mult_div_stall` and `cal_finish` inputs, so flow control freezes IF/ID/EX while a result is pending.

## Interface
Parameters:
- `WIDTH`, 32: operand width; the iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request from execute; sampled only when `busy`=0.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `src_a`  in  WIDTH  rs value: multiplicand or dividend.
- `src_b`  in  WIDTH  rt value: multiplier or divisor.
- `cancel`  in  1  pipeline flush; aborts any operation in flight.
- `busy`  out  1  operation in flight.
- `stall`  out  1  combinational `start | busy`; wired to `mult_div_stall`.
- `done`  out  1  one-cycle pulse when `hi`/`lo` become valid; wired to `cal_finish`.
- `hi`  out  WIDTH  product high half, or remainder.
- `lo`  out  WIDTH  product low half, or quotient.

## Operation
- States: IDLE, CALC, FIX.
- **IDLE, `start`=1:**
  - latch `op`;
  - take magnitudes of the operands (two's-complement abs for signed ops);
  - record the result signs: product/quotient sign = sign(a) ^ sign(b); remainder sign = sign(a);
  - clear counter and accumulator; go to CALC.
- **CALC, multiply:** radix-2 shift-add, one bit of `src_b` per cycle, into a 2×WIDTH accumulator.
- **CALC, divide:** restoring division, one quotient bit per cycle.
- CALC leaves after exactly WIDTH cycles (counter 0..WIDTH-1).
- **FIX:** apply the recorded signs by two's-complement negation, load `hi`/`lo`, pulse `done`, return to IDLE.
- **Divide by zero:** no trap. `lo`=all-ones, `hi`=`src_a` as sampled. Latency is unchanged.
- **DIV 0x80000000 / 0xFFFFFFFF:** `lo`=0x80000000, `hi`=0 (wraparound, no exception).
- **`cancel`:**
  - in any state: go to IDLE next cycle, no `done`, `hi`/`lo` unchanged;
  - it has priority over `start` in the same cycle.
- `start` while `busy`=1 is ignored. Flow control guarantees it does not happen; the bench checks it anyway.
- `hi`/`lo` hold their last result until the next FIX. Write-back copies them at the HI/LO write.

## Timing
- Reset (async assert, sync release): state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0.
- `start` sampled at edge 0.
- `busy`=1 from cycle 1 through cycle WIDTH+1 (CALC cycles 1..WIDTH, FIX cycle WIDTH+1).
- `done`=1 and valid `hi`/`lo` in cycle WIDTH+1 (33 for WIDTH=32), registered.
- `busy` drops in the cycle after `done`.
- `stall` is high from the `start` cycle through the `done` cycle. Execute therefore re-presents nothing and the instruction advances on the cycle after `done`.
- A new `start` is accepted in the cycle after `done` (back-to-back throughput WIDTH+2).
- Reset asserted mid-operation: outputs return to reset values immediately; no `done`.

## Configuration
- `MDU_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle `*` product registered in CALC;
  - FIX follows after 1 CALC cycle, so `done` lands at cycle 2 and `busy` spans cycles 1–2;
  - division timing is unchanged.
- Undefined: all operations take WIDTH+1 cycles as above.

## Structure
- Package `mdu_pkg`:
  - op encodings `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`;
  - state enum `mdu_state_t`;
  - `MDU_WIDTH`=32.
- `define.vh` maps the IR funct fields to these ops.
- Single module; no sub-module. Negation/abs is a local function.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 -> `done` at cycle 33, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. MULTU of the same operands -> `hi`=0x00000002, `lo`=0xFFFFFFFA.
- DIV −7 / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7 / 2 -> `lo`=3, `hi`=1.
- DIVU 0x1234 / 0 -> `lo`=0xFFFFFFFF, `hi`=0x00001234 at cycle 33. DIV 0x80000000 / −1 -> `lo`=0x80000000, `hi`=0.
- `cancel` at cycle 10 of a DIV -> `busy`=0 at cycle 11, no `done`, `hi`/`lo` keep the prior result. Then a new `start` at cycle 12 completes normally.
- Reset pulled low at cycle 20 of a MULT -> outputs zero asynchronously, no `done`. `start` during `busy` -> ignored, the original result is correct.
- `MDU_FAST_MUL_EN` defined: MULT 5 × 6 -> `done` at cycle 2, `lo`=30, `hi`=0. DIV timing still 33 cycles.
